// File: rtl/mine_map_gen.sv
// mine_map_gen: builds a random 8x8 mine map for the play logic.
// Each entry into the GAME_START screen state clears the map. The block then places exactly
// MINE_NUM mines at distinct cells taken from a free-running 16-bit Galois LFSR. Cell 0 is the
// cursor start position, so it is never mined.
// Ports:
//   clk            system clock
//   rst_n          asynchronous active-low reset
//   screen_state_i screen state code; GAME_START selects the code that triggers generation
//   map_o          64-bit mine map, bit y*8+x, 1 = mine
//   map_valid_o    map complete and stable
//   busy_o         placement in progress
module mine_map_gen #(
   parameter int unsigned MINE_NUM   = 10,
   parameter logic [15:0] SEED       = 16'hACE1,
   parameter logic [2:0]  GAME_START = 3'd1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [2:0]  screen_state_i,
   output logic [63:0] map_o,
   output logic        map_valid_o,
   output logic        busy_o
);

   // An all-zero seed would lock the LFSR up.
   localparam logic [15:0] SeedEff = (SEED == 16'h0000) ? 16'h0001 : SEED;
   localparam logic [6:0]  MineNum = 7'(MINE_NUM);
   localparam logic [15:0] Taps    = 16'hB400;

   typedef enum logic [1:0] {StIdle, StPlace, StDone} state_e;

   state_e      state_q, state_d;
   logic [15:0] lfsr_q, lfsr_d;
   logic        start_seen_q;
   logic [6:0]  cnt_q, cnt_d;
   logic [63:0] map_q, map_d;
   logic        valid_q, valid_d;
   logic        busy_q, busy_d;
   logic        is_start;
   logic        trigger;
   logic [5:0]  idx;

   assign is_start = (screen_state_i == GAME_START);
   // Rising edge of "in GAME_START"; also fires if GAME_START is held through reset release.
   assign trigger  = is_start && !start_seen_q;
   assign idx      = lfsr_q[5:0];
   assign lfsr_d   = (lfsr_q >> 1) ^ (lfsr_q[0] ? Taps : 16'h0000);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      map_d   = map_q;
      valid_d = valid_q;
      busy_d  = busy_q;
      if (trigger) begin
         // Restart from any state, including mid-placement.
         state_d = StPlace;
         cnt_d   = 7'd0;
         map_d   = 64'd0;
         valid_d = 1'b0;
         busy_d  = 1'b1;
      end else begin
         unique case (state_q)
            StPlace: begin
               // Occupied cells and cell 0 are skipped; the LFSR moves on regardless.
               if (idx != 6'd0 && !map_q[idx]) begin
                  map_d[idx] = 1'b1;
                  cnt_d      = cnt_q + 7'd1;
                  if (cnt_d == MineNum) begin
                     state_d = StDone;
                     valid_d = 1'b1;
                     busy_d  = 1'b0;
                  end
               end
            end
            StIdle, StDone: ;
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         lfsr_q       <= SeedEff;
         start_seen_q <= 1'b0;
         cnt_q        <= 7'd0;
         map_q        <= 64'd0;
         valid_q      <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         lfsr_q       <= lfsr_d;
         start_seen_q <= is_start;
         cnt_q        <= cnt_d;
         map_q        <= map_d;
         valid_q      <= valid_d;
         busy_q       <= busy_d;
      end
   end

   assign map_o       = map_q;
   assign map_valid_o = valid_q;
   assign busy_o      = busy_q;

endmodule

// File: tb/tb_mine_map_gen.sv
// Testbench for mine_map_gen: two instances (10 and 63 mines) share clock, reset and screen
// state; a behavioural model predicts every generated map and its latency.
module tb_mine_map_gen;

   localparam logic [2:0]  GS   = 3'd1;
   localparam logic [2:0]  GP   = 3'd2;
   localparam logic [15:0] Seed = 16'hACE1;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [2:0]  screen_state = GP;
   logic [63:0] map10, map63;
   logic        valid10, valid63, busy10, busy63;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mine_map_gen #(.MINE_NUM(10), .SEED(Seed), .GAME_START(GS)) dut10 (
      .clk(clk), .rst_n(rst_n), .screen_state_i(screen_state),
      .map_o(map10), .map_valid_o(valid10), .busy_o(busy10)
   );

   mine_map_gen #(.MINE_NUM(63), .SEED(Seed), .GAME_START(GS)) dut63 (
      .clk(clk), .rst_n(rst_n), .screen_state_i(screen_state),
      .map_o(map63), .map_valid_o(valid63), .busy_o(busy63)
   );

   // ---------------- reference model ----------------
   function automatic logic [15:0] lfsr_next(input logic [15:0] v);
      return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
   endfunction

   // Draw cells from the LFSR sequence starting at 'start' until n distinct nonzero cells hit.
   function automatic void gen_map(input logic [15:0] start, input int n,
                                   output logic [63:0] m, output int cyc);
      logic [15:0] v;
      int          placed;
      v = start; m = 64'd0; placed = 0; cyc = 0;
      while (placed < n && cyc < 10000000) begin
         cyc++;
         if (v[5:0] != 6'd0 && !m[v[5:0]]) begin
            m[v[5:0]] = 1'b1;
            placed++;
         end
         v = lfsr_next(v);
      end
   endfunction

   logic [15:0] m_lfsr;
   logic        m_prev_start;
   logic [63:0] gold10, gold63;
   int          cyc10, cyc63;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_lfsr       = Seed;
         m_prev_start = 1'b0;
      end else begin
         if (screen_state == GS && !m_prev_start) begin
            // First attempt uses the value the LFSR holds after the trigger edge.
            gen_map(lfsr_next(m_lfsr), 10, gold10, cyc10);
            gen_map(lfsr_next(m_lfsr), 63, gold63, cyc63);
         end
         m_prev_start = (screen_state == GS);
         m_lfsr       = lfsr_next(m_lfsr);
      end
   end

   // ---------------- helpers ----------------
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
      end
   endtask

   // Called at the negedge right after the trigger edge; returns cycles until valid10.
   task automatic wait_valid10(output int k);
      k = 0;
      while (!valid10 && k < 5000) begin
         @(negedge clk);
         k++;
      end
   endtask

   task automatic check_cleared(input string tag);
      chk({tag, "_map_clear"}, map10, 64'd0);
      chk({tag, "_busy"}, 64'(busy10), 64'd1);
      chk({tag, "_valid_low"}, 64'(valid10), 64'd0);
   endtask

   task automatic check_final(input string tag, input int k, input logic [63:0] gm,
                              input int gc);
      chk({tag, "_valid"}, 64'(valid10), 64'd1);
      chk({tag, "_latency"}, 64'(k), 64'(gc));
      chk({tag, "_map"}, map10, gm);
      chk({tag, "_popcount"}, 64'($countones(map10)), 64'd10);
      chk({tag, "_cell0"}, 64'(map10[0]), 64'd0);
      chk({tag, "_busy_low"}, 64'(busy10), 64'd0);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int          k;
      int          bad;
      logic [63:0] first_map, snap, gm;
      int          gc;

      // 1: reset with GAME_PLAY, outputs idle for 100 cycles.
      repeat (3) @(negedge clk);
      chk("rst_map", map10, 64'd0);
      chk("rst_valid", 64'(valid10), 64'd0);
      chk("rst_busy", 64'(busy10), 64'd0);
      rst_n = 1'b1;
      bad = 0;
      repeat (100) begin
         @(negedge clk);
         if (map10 !== 64'd0 || valid10 !== 1'b0 || busy10 !== 1'b0) bad++;
      end
      chk("idle_100", 64'(bad), 64'd0);

      // 2: GAME_START held through reset release.
      rst_n = 1'b0;
      screen_state = GS;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_cleared("boot");
      gm = gold10; gc = cyc10;
      wait_valid10(k);
      chk("boot_latency_min", 64'(k >= 10), 64'd1);
      check_final("boot", k, gm, gc);
      first_map = map10;
      k = 0;
      while (!valid63 && k < 5000) begin
         @(negedge clk);
         k++;
      end
      chk("full_valid", 64'(valid63), 64'd1);
      chk("full_map", map63, 64'hFFFF_FFFF_FFFF_FFFE);
      chk("full_model", map63, gold63);

      // 3: GAME_START held 1000 cycles after DONE: no retrigger, outputs stable.
      snap = map10;
      bad = 0;
      repeat (1000) begin
         @(negedge clk);
         if (map10 !== snap || valid10 !== 1'b1 || busy10 !== 1'b0) bad++;
      end
      chk("hold_stable", 64'(bad), 64'd0);

      // 4: retriggers after DONE with random dwell in GAME_PLAY.
      for (int r = 0; r < 3; r++) begin
         screen_state = GP;
         repeat ($urandom_range(1, 40)) @(negedge clk);
         screen_state = GS;
         @(negedge clk);
         check_cleared($sformatf("retrig%0d", r));
         gm = gold10; gc = cyc10;
         wait_valid10(k);
         check_final($sformatf("retrig%0d", r), k, gm, gc);
      end

      // Retrigger while busy; leaving GAME_START must not abort.
      screen_state = GP;
      repeat ($urandom_range(1, 20)) @(negedge clk);
      screen_state = GS;
      @(negedge clk);
      check_cleared("busy_t1");
      screen_state = GP;
      repeat (2) @(negedge clk);
      chk("busy_t1_running", 64'(busy10), 64'd1);
      screen_state = GS;
      @(negedge clk);
      check_cleared("busy_t2");
      gm = gold10; gc = cyc10;
      screen_state = GP;
      wait_valid10(k);
      check_final("busy_t2", k, gm, gc);

      // 5: asynchronous reset mid-PLACE, GAME_START kept asserted.
      screen_state = GS;
      @(negedge clk);
      repeat (3) @(negedge clk);
      chk("pre_rst_busy", 64'(busy10), 64'd1);
      #1 rst_n = 1'b0;
      #1;
      chk("async_map", map10, 64'd0);
      chk("async_busy", 64'(busy10), 64'd0);
      chk("async_valid", 64'(valid10), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_cleared("rerst");
      gm = gold10; gc = cyc10;
      wait_valid10(k);
      check_final("rerst", k, gm, gc);
      chk("rerst_same_as_boot", map10, first_map);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
